// File: rtl/stage3_hazard_controller.sv
// Hazard sequencer for the 3-stage F/D -> EX -> MEM/WB core: resolves load-use,
// data-memory wait, redirect-with-fetch-in-flight and halt draining.
module stage3_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic             rs1_used_e,
  input  logic             rs2_used_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             load_m,
  input  logic             dmem_busy,
  input  logic             imem_busy,
  input  logic             redirect_e,
  input  logic             halt_req_e,
  input  logic             clr_cnt,
  output logic             stall_fd,
  output logic             stall_ex,
  output logic             stall_m,
  output logic             bubble_m,
  output logic             flush_fd,
  output logic             discard_fetch,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    RUN           = 3'd0,
    LOAD_WAIT     = 3'd1,
    FETCH_DISCARD = 3'd2,
    DRAIN         = 3'd3,
    HALTED        = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nxt;
  logic   load_use;
  logic   load_inc;
  logic   flush_inc;

  assign load_use = load_m & reg_write_m & (rd_m != 5'd0) &
                    ((rs1_used_e & (rs1_e == rd_m)) | (rs2_used_e & (rs2_e == rd_m)));

  assign state_o = state;

  // Control outputs are a pure function of the current state and this cycle's inputs.
  always_comb begin
    state_nxt     = state;
    stall_fd      = 1'b0;
    stall_ex      = 1'b0;
    stall_m       = 1'b0;
    bubble_m      = 1'b0;
    flush_fd      = 1'b0;
    discard_fetch = 1'b0;
    halted        = 1'b0;
    load_inc      = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      RUN: begin
        if (halt_req_e && !dmem_busy) begin
          stall_fd  = 1'b1;
          flush_fd  = 1'b1;
          state_nxt = DRAIN;
        end else if (dmem_busy) begin
          stall_fd = 1'b1;
          stall_ex = 1'b1;
          stall_m  = 1'b1;
          if (load_use) begin
            load_inc  = 1'b1;
            state_nxt = LOAD_WAIT;
          end
        end else if (load_use) begin
          stall_fd = 1'b1;
          stall_ex = 1'b1;
          bubble_m = 1'b1;
          load_inc = 1'b1;
        end else if (redirect_e) begin
          flush_fd  = 1'b1;
          flush_inc = 1'b1;
          if (imem_busy) begin
            discard_fetch = 1'b1;
            state_nxt     = FETCH_DISCARD;
          end
        end
      end

      LOAD_WAIT: begin
        load_inc = 1'b1;
        stall_fd = 1'b1;
        stall_ex = 1'b1;
        if (dmem_busy) begin
          stall_m = 1'b1;
        end else begin
          bubble_m  = 1'b1;
          state_nxt = RUN;
        end
      end

      // EX holds a bubble here, so redirect/load-use/halt cannot originate from it.
      FETCH_DISCARD: begin
        flush_fd      = 1'b1;
        discard_fetch = 1'b1;
        if (dmem_busy) begin
          stall_fd = 1'b1;
          stall_ex = 1'b1;
          stall_m  = 1'b1;
        end
        if (!imem_busy) state_nxt = RUN;
      end

      DRAIN: begin
        stall_fd      = 1'b1;
        flush_fd      = 1'b1;
        bubble_m      = 1'b1;
        discard_fetch = imem_busy;
        if (dmem_busy) begin
          stall_ex = 1'b1;
          stall_m  = 1'b1;
        end
        if (!dmem_busy && !imem_busy) state_nxt = HALTED;
      end

      HALTED: begin
        stall_fd = 1'b1;
        flush_fd = 1'b1;
        bubble_m = 1'b1;
        halted   = 1'b1;
        if (dmem_busy) begin
          stall_ex = 1'b1;
          stall_m  = 1'b1;
        end
      end

      default: state_nxt = RUN;
    endcase
  end

  // Counters saturate instead of wrapping; a clear beats a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= RUN;
      load_stall_cnt <= '0;
      mem_stall_cnt  <= '0;
      flush_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (clr_cnt) begin
        load_stall_cnt <= '0;
        mem_stall_cnt  <= '0;
        flush_cnt      <= '0;
      end else begin
        if (load_inc && (load_stall_cnt != CNT_MAX)) load_stall_cnt <= load_stall_cnt + CNT_ONE;
        if (dmem_busy && (mem_stall_cnt != CNT_MAX)) mem_stall_cnt <= mem_stall_cnt + CNT_ONE;
        if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_stage3_hazard_controller.sv
// Directed bench for stage3_hazard_controller (CNT_W=4 so saturation is reachable).
module tb_stage3_hazard_controller;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [4:0]       rs1_e, rs2_e, rd_m;
  logic             rs1_used_e, rs2_used_e, reg_write_m, load_m;
  logic             dmem_busy, imem_busy, redirect_e, halt_req_e, clr_cnt;
  logic             stall_fd, stall_ex, stall_m, bubble_m, flush_fd, discard_fetch, halted;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] load_stall_cnt, mem_stall_cnt, flush_cnt;
  logic [6:0]       ctrl;

  int compared   = 0;
  int mismatched = 0;

  stage3_hazard_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_used_e(rs1_used_e), .rs2_used_e(rs2_used_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .load_m(load_m),
    .dmem_busy(dmem_busy), .imem_busy(imem_busy), .redirect_e(redirect_e),
    .halt_req_e(halt_req_e), .clr_cnt(clr_cnt),
    .stall_fd(stall_fd), .stall_ex(stall_ex), .stall_m(stall_m), .bubble_m(bubble_m),
    .flush_fd(flush_fd), .discard_fetch(discard_fetch), .halted(halted),
    .state_o(state_o), .load_stall_cnt(load_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Bit order: stall_fd, stall_ex, stall_m, bubble_m, flush_fd, discard_fetch, halted
  assign ctrl = {stall_fd, stall_ex, stall_m, bubble_m, flush_fd, discard_fetch, halted};

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rs1_e = 0; rs2_e = 0; rd_m = 0; rs1_used_e = 0; rs2_used_e = 0;
    reg_write_m = 0; load_m = 0; dmem_busy = 0; imem_busy = 0;
    redirect_e = 0; halt_req_e = 0; clr_cnt = 0;
  endtask

  task automatic clear_counters();
    idle(); clr_cnt = 1; cyc(); clr_cnt = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    rs1_e = 5'd31; rs2_e = 5'd31; rd_m = 5'd31; rs1_used_e = 1; rs2_used_e = 1;
    reg_write_m = 1; load_m = 1; dmem_busy = 1; imem_busy = 1;
    redirect_e = 1; halt_req_e = 1; clr_cnt = 1;
    cyc(); cyc();
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL rst_state: got %0d want 0", state_o); end
    compared++; if (ctrl !== 7'b1110000) begin mismatched++; $display("[TB] FAIL rst_busy_ctrl: got %b want 1110000", ctrl); end
    idle(); #1;
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL rst_idle_ctrl: got %b want 0000000", ctrl); end
    nRST = 1; cyc();
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL rel_state: got %0d want 0", state_o); end
    compared++; if ({load_stall_cnt, mem_stall_cnt, flush_cnt} !== 12'h000) begin mismatched++; $display("[TB] FAIL rel_cnts: got %h want 000", {load_stall_cnt, mem_stall_cnt, flush_cnt}); end
  endtask

  task automatic test_load_use();
    idle(); load_m = 1; reg_write_m = 1; rd_m = 5'd5; rs1_e = 5'd5; rs1_used_e = 1; #1;
    compared++; if (ctrl !== 7'b1101000) begin mismatched++; $display("[TB] FAIL lu_rs1_ctrl: got %b want 1101000", ctrl); end
    cyc(); idle(); #1;
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL lu_after_ctrl: got %b want 0000000", ctrl); end
    compared++; if (load_stall_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL lu_cnt1: got %0d want 1", load_stall_cnt); end
    load_m = 1; reg_write_m = 1; rd_m = 5'd0; rs1_e = 5'd0; rs1_used_e = 1; #1;
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL lu_rd0_ctrl: got %b want 0000000", ctrl); end
    cyc(); idle(); load_m = 1; reg_write_m = 1; rd_m = 5'd7; rs2_e = 5'd7; rs2_used_e = 1; rs1_e = 5'd3; rs1_used_e = 1; #1;
    compared++; if (ctrl !== 7'b1101000) begin mismatched++; $display("[TB] FAIL lu_rs2_ctrl: got %b want 1101000", ctrl); end
    cyc(); rs2_used_e = 0; #1;
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL lu_rs2_unused_ctrl: got %b want 0000000", ctrl); end
    cyc(); reg_write_m = 0; rs2_used_e = 1; #1;
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL lu_nowrite_ctrl: got %b want 0000000", ctrl); end
    cyc(); idle();
    compared++; if (load_stall_cnt !== 4'd2) begin mismatched++; $display("[TB] FAIL lu_cnt2: got %0d want 2", load_stall_cnt); end
  endtask

  task automatic test_load_wait();
    clear_counters();
    load_m = 1; reg_write_m = 1; rd_m = 5'd9; rs2_e = 5'd9; rs2_used_e = 1; dmem_busy = 1; #1;
    compared++; if (ctrl !== 7'b1110000) begin mismatched++; $display("[TB] FAIL lw_entry_ctrl: got %b want 1110000", ctrl); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL lw_state_busy%0d: got %0d want 1", i, state_o); end
      compared++; if (ctrl !== 7'b1110000) begin mismatched++; $display("[TB] FAIL lw_busy_ctrl%0d: got %b want 1110000", i, ctrl); end
    end
    cyc(); dmem_busy = 0; #1;
    compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL lw_state_bubble: got %0d want 1", state_o); end
    compared++; if (ctrl !== 7'b1101000) begin mismatched++; $display("[TB] FAIL lw_bubble_ctrl: got %b want 1101000", ctrl); end
    cyc(); idle(); #1;
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL lw_exit_state: got %0d want 0", state_o); end
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL lw_exit_ctrl: got %b want 0000000", ctrl); end
    compared++; if (mem_stall_cnt !== 4'd3) begin mismatched++; $display("[TB] FAIL lw_mem_cnt: got %0d want 3", mem_stall_cnt); end
    compared++; if (load_stall_cnt !== 4'd4) begin mismatched++; $display("[TB] FAIL lw_load_cnt: got %0d want 4", load_stall_cnt); end
  endtask

  task automatic test_redirect();
    clear_counters();
    redirect_e = 1; imem_busy = 1; #1;
    compared++; if (ctrl !== 7'b0000110) begin mismatched++; $display("[TB] FAIL rd_c0_ctrl: got %b want 0000110", ctrl); end
    cyc();
    compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL rd_c1_state: got %0d want 2", state_o); end
    compared++; if (ctrl !== 7'b0000110) begin mismatched++; $display("[TB] FAIL rd_c1_ctrl: got %b want 0000110", ctrl); end
    cyc(); redirect_e = 0; imem_busy = 0; #1;
    compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL rd_c2_state: got %0d want 2", state_o); end
    compared++; if (ctrl !== 7'b0000110) begin mismatched++; $display("[TB] FAIL rd_c2_ctrl: got %b want 0000110", ctrl); end
    cyc();
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL rd_exit_state: got %0d want 0", state_o); end
    compared++; if (ctrl !== 7'b0000000) begin mismatched++; $display("[TB] FAIL rd_exit_ctrl: got %b want 0000000", ctrl); end
    compared++; if (flush_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL rd_cnt1: got %0d want 1", flush_cnt); end
    redirect_e = 1; #1;
    compared++; if (ctrl !== 7'b0000100) begin mismatched++; $display("[TB] FAIL rd_nobusy_ctrl: got %b want 0000100", ctrl); end
    cyc();
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL rd_nobusy_state: got %0d want 0", state_o); end
    load_m = 1; reg_write_m = 1; rd_m = 5'd4; rs1_e = 5'd4; rs1_used_e = 1; #1;
    compared++; if (ctrl !== 7'b1101000) begin mismatched++; $display("[TB] FAIL rd_lu_ctrl: got %b want 1101000", ctrl); end
    cyc(); idle();
    compared++; if (flush_cnt !== 4'd2) begin mismatched++; $display("[TB] FAIL rd_cnt2: got %0d want 2", flush_cnt); end
  endtask

  task automatic test_halt();
    clear_counters();
    halt_req_e = 1; dmem_busy = 1; #1;
    compared++; if (ctrl !== 7'b1110000) begin mismatched++; $display("[TB] FAIL hl_busy_ctrl: got %b want 1110000", ctrl); end
    cyc();
    compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL hl_busy_state: got %0d want 0", state_o); end
    dmem_busy = 0; imem_busy = 1; #1;
    compared++; if (ctrl !== 7'b1000100) begin mismatched++; $display("[TB] FAIL hl_accept_ctrl: got %b want 1000100", ctrl); end
    cyc(); halt_req_e = 0; #1;
    compared++; if (state_o !== 3'd3) begin mismatched++; $display("[TB] FAIL hl_drain_state: got %0d want 3", state_o); end
    compared++; if (ctrl !== 7'b1001110) begin mismatched++; $display("[TB] FAIL hl_drain_ctrl: got %b want 1001110", ctrl); end
    cyc(); imem_busy = 0; #1;
    compared++; if (ctrl !== 7'b1001100) begin mismatched++; $display("[TB] FAIL hl_drain2_ctrl: got %b want 1001100", ctrl); end
    cyc(); redirect_e = 1;
    for (int i = 0; i < 100; i++) begin
      compared++; if ({state_o, ctrl} !== {3'd4, 7'b1001101}) begin mismatched++; $display("[TB] FAIL hl_sticky%0d: got %0d/%b want 4/1001101", i, state_o, ctrl); end
      cyc();
    end
    compared++; if (flush_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL hl_flush_cnt: got %0d want 0", flush_cnt); end
    idle(); nRST = 0; cyc(); nRST = 1; #1;
    compared++; if ({state_o, ctrl} !== {3'd0, 7'b0000000}) begin mismatched++; $display("[TB] FAIL hl_reset: got %0d/%b want 0/0000000", state_o, ctrl); end
  endtask

  task automatic test_saturation();
    clear_counters();
    dmem_busy = 1;
    for (int i = 0; i < 20; i++) cyc();
    compared++; if (mem_stall_cnt !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_mem_cnt: got %0d want 15", mem_stall_cnt); end
    clr_cnt = 1; cyc(); clr_cnt = 0;
    compared++; if (mem_stall_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL sat_clr: got %0d want 0", mem_stall_cnt); end
    cyc(); idle();
    compared++; if (mem_stall_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL sat_after_clr: got %0d want 1", mem_stall_cnt); end
  endtask

  initial begin
    idle();
    nRST = 0;
    test_reset();
    test_load_use();
    test_load_wait();
    test_redirect();
    test_halt();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
